cmul_operand_loader: RTL and testbench

- Upstream feeder for the complex-multiplier step sequencer and its datapath.
- Accepts operand pairs (a_re + j·a_im, b_re + j·b_im) over a valid/ready handshake into a small FIFO.
- Pops one pair at a time into holding registers and issues a one-cycle `ie` start pulse.
- Keeps the operands stable until the sequencer's final-step enable (`p_i_ce`, wired to `mul_done`) returns.

---
 rtl/cmul_operand_loader.sv | 181 ++++++++++++++++++
 tb/tb_cmul_operand_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : cmul_operand_loader
// Description : Operand-pair FIFO feeding the complex-multiplier sequencer;
//               pops one pair, pulses ie, holds operands until mul_done.
//               Optional macro CMUL_CONJ_EN adds in_conj (store conj(b)).
// Revision    : 1.0 - initial release
// ============================================================================
module cmul_operand_loader #(
    parameter int W       = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a_re,
    input  logic [W-1:0]            in_a_im,
    input  logic [W-1:0]            in_b_re,
    input  logic [W-1:0]            in_b_im,
`ifdef CMUL_CONJ_EN
    input  logic                    in_conj,
`endif
    output logic                    ie,
    input  logic                    mul_done,
    output logic [W-1:0]            op_a_re,
    output logic [W-1:0]            op_a_im,
    output logic [W-1:0]            op_b_re,
    output logic [W-1:0]            op_b_im,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [7:0]              launch_cnt,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [4*W-1:0]  r_mem [DEPTH];
    logic [4*W-1:0]  w_head;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [c_TW-1:0] r_tmr;
    logic [W-1:0]    w_b_im_store;
    logic            w_push;
    logic            w_pop;
    logic            w_launch;
    logic            w_tmo;

`ifdef CMUL_CONJ_EN
    localparam logic [W-1:0] c_MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_MOST_POS = {1'b0, {(W-1){1'b1}}};

    // Negating the most-negative value would overflow back to itself; clamp it.
    always_comb begin
        w_b_im_store = in_b_im;
        if (in_conj) begin
            w_b_im_store = (in_b_im == c_MOST_NEG) ? c_MOST_POS : ({W{1'b0}} - in_b_im);
        end
    end
`else
    assign w_b_im_store = in_b_im;
`endif

    // Ready depends on occupancy only, so a full FIFO refuses even while popping.
    assign in_ready = (r_level != c_FULL);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a_re, in_a_im, in_b_re, w_b_im_store};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_launch     = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_launch     = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    w_state_next = S_IDLE;
                end else if (r_tmr == c_TMO_LAST) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign ie   = (r_state == S_LAUNCH);
    assign busy = (r_state != S_IDLE);

    // Operands only move on a pop, so they hold through LAUNCH and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_re     <= '0;
            op_a_im     <= '0;
            op_b_re     <= '0;
            op_b_im     <= '0;
            launch_cnt  <= '0;
            r_tmr       <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (w_pop) begin
                op_a_re <= w_head[4*W-1:3*W];
                op_a_im <= w_head[3*W-1:2*W];
                op_b_re <= w_head[2*W-1:W];
                op_b_im <= w_head[W-1:0];
            end
            if (w_launch) begin
                launch_cnt <= launch_cnt + 8'd1;
                r_tmr      <= '0;
            end else if ((r_state == S_WAIT) && !mul_done) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (w_tmo) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_cmul_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmul_operand_loader
// Description : Self-checking bench for cmul_operand_loader against a
//               queue-based reference model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmul_operand_loader;

    localparam int W       = 16;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic           in_conj = 1'b0;
    logic           ie;
    logic           mul_done;
    logic           auto_done = 1'b0;
    logic           man_done = 1'b0;
    logic           auto_en = 1'b0;
    logic [W-1:0]   op_a_re, op_a_im, op_b_re, op_b_im;
    logic           busy, err_timeout;
    logic [7:0]     launch_cnt;
    logic [$clog2(DEPTH):0] fifo_level;

    assign mul_done = auto_done | man_done;

    always #5 clk = ~clk;

    cmul_operand_loader #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
`ifdef CMUL_CONJ_EN
        .in_conj(in_conj),
`endif
        .ie(ie), .mul_done(mul_done),
        .op_a_re(op_a_re), .op_a_im(op_a_im), .op_b_re(op_b_re), .op_b_im(op_b_im),
        .busy(busy), .err_timeout(err_timeout),
        .launch_cnt(launch_cnt), .fifo_level(fifo_level)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = no operation held, 1 = start cycle, 2 = awaiting completion
    logic [4*W-1:0] mq[$];
    logic [4*W-1:0] m_e;
    logic [W-1:0]   m_op [4];
    int             m_mode, m_wait, m_cnt;
    bit             m_err, m_push;

    function automatic logic [W-1:0] stored_bim(input logic [W-1:0] v, input logic c);
        int s;
        s = $signed(v);
        if (c) begin
            s = -s;
            if (s > (2**(W-1)) - 1) s = (2**(W-1)) - 1;
        end
        return s[W-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_mode = 0; m_wait = 0; m_cnt = 0; m_err = 0;
            for (int k = 0; k < 4; k++) m_op[k] = '0;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            if (m_mode == 0) begin
                if (mq.size() > 0) begin
                    m_e = mq.pop_front();
                    m_op[0] = m_e[4*W-1:3*W]; m_op[1] = m_e[3*W-1:2*W];
                    m_op[2] = m_e[2*W-1:W];   m_op[3] = m_e[W-1:0];
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_cnt = (m_cnt + 1) % 256;
                m_wait = 0;
                m_mode = 2;
            end else begin
                if (mul_done) m_mode = 0;
                else if (m_wait == TIMEOUT - 1) begin m_err = 1; m_mode = 0; end
                else m_wait++;
            end
            if (m_push) begin
`ifdef CMUL_CONJ_EN
                mq.push_back({in_a_re, in_a_im, in_b_re, stored_bim(in_b_im, in_conj)});
`else
                mq.push_back({in_a_re, in_a_im, in_b_re, stored_bim(in_b_im, 1'b0)});
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (mq.size() < DEPTH));
        chk("ie", ie, (m_mode == 1));
        chk("busy", busy, (m_mode != 0));
        chk("err_timeout", err_timeout, m_err);
        chk("launch_cnt", launch_cnt, m_cnt);
        chk("fifo_level", fifo_level, mq.size());
        chk("op_a_re", op_a_re, m_op[0]);
        chk("op_a_im", op_a_im, m_op[1]);
        chk("op_b_re", op_b_re, m_op[2]);
        chk("op_b_im", op_b_im, m_op[3]);
    end

    // ---------------- event monitor & sequencer stand-in ----------------
    logic [3:0]     sh = '0;
    int             ie_cyc[$];
    logic [W-1:0]   ie_a[$], ie_bim[$];
    int             ie_total = 0, done_cyc = -1, busy_fall = -1, err_rise = -1;
    bit             prev_busy = 0, prev_err = 0, saw_full = 0;

    always @(negedge clk) begin
        if (rst) begin
            sh = '0; prev_busy = 0; prev_err = 0;
        end else begin
            sh = {sh[2:0], ie};
            if (ie) begin
                ie_cyc.push_back(cyc); ie_a.push_back(op_a_re);
                ie_bim.push_back(op_b_im); ie_total++;
            end
            if (mul_done) done_cyc = cyc;
            if (prev_busy && !busy) busy_fall = cyc;
            if (!prev_err && err_timeout) err_rise = cyc;
            if (!in_ready) saw_full = 1;
            prev_busy = busy; prev_err = err_timeout;
        end
    end

    // mul_done returns four cycles after the start pulse
    always @(posedge clk) begin
        #1;
        auto_done = auto_en && sh[3];
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2; cyc++;
    endtask

    task automatic drive(input int ar, input int ai, input int br, input int bi, input logic c);
        int v;
        v = ar; in_a_re = v[W-1:0];
        v = ai; in_a_im = v[W-1:0];
        v = br; in_b_re = v[W-1:0];
        v = bi; in_b_im = v[W-1:0];
        in_conj  = c;
        in_valid = 1'b1;
    endtask

    task automatic push(input int ar, input int ai, input int br, input int bi, input logic c);
        int n;
        n = 0;
        drive(ar, ai, br, bi, c);
        while (!in_ready && n < 50) begin step(); n++; end
        chk("push_wait_bound", (n < 50), 1);
        step();
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || fifo_level != 0) && n < lim) begin step(); n++; end
        chk("drain_bound", (n < lim), 1);
    endtask

    initial begin
        int c0, n, start_cnt, n0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_launch_cnt", launch_cnt, 0);
        chk("rst_level", fifo_level, 0);

        // single operation: a=3+j4, b=5-j2
        auto_en = 1'b1;
        c0 = cyc;
        drive(3, 4, 5, -2, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("t1_ie_count", ie_cyc.size(), 1);
        chk("t1_ie_cycle", ie_cyc[0] - c0, 2);
        chk("t1_op_a_re", ie_a[0], 3);
        chk("t1_op_b_im", ie_bim[0], 16'hFFFE);
        chk("t1_done_cycle", done_cyc - c0, 6);
        chk("t1_busy_fall", busy_fall - c0, 7);
        chk("t1_launch_cnt", launch_cnt, 1);

        // three back-to-back pushes into a two-deep FIFO
        ie_cyc.delete(); ie_a.delete(); ie_bim.delete(); saw_full = 0;
        push(10, 1, 2, 3, 1'b0);
        push(20, 4, 5, 6, 1'b0);
        push(30, 7, 8, 9, 1'b0);
        in_valid = 1'b0;
        wait_idle(100);
        chk("t2_ie_count", ie_cyc.size(), 3);
        chk("t2_gap1", ie_cyc[1] - ie_cyc[0], 6);
        chk("t2_gap2", ie_cyc[2] - ie_cyc[1], 6);
        chk("t2_order0", ie_a[0], 10);
        chk("t2_order1", ie_a[1], 20);
        chk("t2_order2", ie_a[2], 30);
        chk("t2_saw_full", saw_full, 1);
        chk("t2_launch_cnt", launch_cnt, 4);

        // timeout with a second pair queued behind
        ie_cyc.delete(); ie_a.delete(); ie_bim.delete();
        auto_en = 1'b0;
        push(40, 0, 1, 1, 1'b0);
        push(50, 0, 1, 1, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!err_timeout && n < 40) begin step(); n++; end
        chk("t3_err_bound", (n < 40), 1);
        auto_en = 1'b1;
        wait_idle(100);
        chk("t3_err_delay", err_rise - ie_cyc[0], 9);
        chk("t3_ie_count", ie_cyc.size(), 2);
        chk("t3_second_a", ie_a[1], 50);
        chk("t3_err_sticky", err_timeout, 1);
        chk("t3_launch_cnt", launch_cnt, 6);

        // stray mul_done while idle
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        repeat (3) step();
        chk("t4_busy", busy, 0);
        chk("t4_ie_count", ie_cyc.size(), 2);

        // reset in WAIT with one pair still queued
        auto_en = 1'b0;
        ie_cyc.delete();
        push(60, 0, 0, 0, 1'b0);
        push(70, 0, 0, 0, 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (ie_cyc.size() == 0 && n < 20) begin step(); n++; end
        step(); step();
        chk("t5_level_before", fifo_level, 1);
        chk("t5_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ie", ie, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_err", err_timeout, 0);
        chk("t5_rst_cnt", launch_cnt, 0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_op", {op_a_re, op_b_im}, 0);
        step(); step();
        rst = 1'b0;
        repeat (12) step();
        chk("t5_no_ie_after", ie_cyc.size(), 1);

        auto_en = 1'b1;
`ifdef CMUL_CONJ_EN
        ie_bim.delete();
        push(1, 1, 1, 7, 1'b1);
        push(1, 1, 1, -32768, 1'b1);
        in_valid = 1'b0; in_conj = 1'b0;
        wait_idle(100);
        push(1, 1, 1, -5, 1'b0);
        in_valid = 1'b0;
        wait_idle(100);
        chk("conj_neg7", ie_bim[0], 16'hFFF9);
        chk("conj_sat", ie_bim[1], 16'h7FFF);
        chk("conj_off", ie_bim[2], 16'hFFFB);
`endif

        // 256 launches bring the counter back round
        start_cnt = launch_cnt;
        n0 = ie_total;
        drive(11, 12, 13, 14, 1'b0);
        n = 0;
        while (ie_total < n0 + 256 && n < 2000) begin step(); n++; end
        chk("wrap_bound", (n < 2000), 1);
        chk("wrap_launch_cnt", launch_cnt, start_cnt);
        in_valid = 1'b0;
        wait_idle(100);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
